// File: rtl/prd_seg_if.sv
// prd_seg_if
//   Groups the two handshakes of prd_seg into one bundle:
//   - PRD fetch channel towards the ctba fetcher
//     (al2ctba_req / ctba2al_ack plus the PRD fields).
//   - Segment descriptor channel towards the bus consumer
//     (seg_valid / seg_ready plus the descriptor).
//   It also carries a read-only debug copy of the sequencer state.
//
// Handshake semantics:
//   Segment channel: a transfer happens on every rising clock edge where
//   seg_valid and seg_ready are both high. Once seg_valid rises, seg_valid,
//   seg_addr and seg_len stay constant until that edge. seg_ready may be
//   driven freely and may depend on seg_valid.
//   PRD channel: al2ctba_req rises and stays high until the edge that samples
//   ctba2al_ack. ack is a single-cycle pulse, and the PRD fields are only
//   meaningful in that cycle.
//
// Modports:
//   master - prd_seg side (drives req, segment descriptor, dbg_state)
//   slave  - fetcher / consumer side
interface prd_seg_if #(
    parameter int C_SEG_SHIFT = 12
);
    logic                   al2ctba_req;
    logic                   ctba2al_ack;
    logic [31:0]            ctba2al_addr;
    logic [21:0]            ctba2al_len;
    logic                   ctba2al_end;

    logic                   seg_valid;
    logic                   seg_ready;
    logic [31:0]            seg_addr;
    logic [C_SEG_SHIFT:0]   seg_len;

    logic [2:0]             dbg_state;

    modport master (
        output al2ctba_req,
        input  ctba2al_ack,
        input  ctba2al_addr,
        input  ctba2al_len,
        input  ctba2al_end,
        output seg_valid,
        input  seg_ready,
        output seg_addr,
        output seg_len,
        output dbg_state
    );

    modport slave (
        input  al2ctba_req,
        output ctba2al_ack,
        output ctba2al_addr,
        output ctba2al_len,
        output ctba2al_end,
        input  seg_valid,
        output seg_ready,
        input  seg_addr,
        input  seg_len,
        input  dbg_state
    );
endinterface

// File: rtl/prd_seg.sv
// prd_seg
//   PRD segmenter. It sits between the DMA address layer and the ctba PRD
//   fetcher. It pulls PRD entries on demand and cuts each data transfer into
//   bus segments. A segment never crosses a 2^C_SEG_SHIFT-byte aligned
//   boundary, and it never exceeds what is left of the current PRD or of the
//   transfer. A partially used PRD survives across transfers. prdbc
//   accumulates the bytes moved since the last ctx_clr.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   xfer_start          pulse: start a transfer of xfer_len bytes (IDLE only)
//   xfer_len[22:0]      transfer byte count
//   ctx_clr             pulse: drop PRD context, clear prdbc, abort
//   xfer_done           one-cycle pulse at the end of a transfer
//   xfer_err            with xfer_done: the PRD table ran out
//   prdbc[31:0]         cumulative byte count
//   bus                 prd_seg_if.master: PRD fetch and segment channels,
//                       plus a debug copy of the state
module prd_seg #(
    parameter int C_SEG_SHIFT = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        xfer_start,
    input  logic [22:0] xfer_len,
    input  logic        ctx_clr,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic [31:0] prdbc,
    prd_seg_if.master   bus
);
    // Remaining-byte counters are 23 bits so that a full 4 MiB PRD fits.
    localparam int RW = 23;
    localparam int LW = C_SEG_SHIFT + 1;
    localparam logic [LW-1:0] SEG_MAX = {1'b1, {C_SEG_SHIFT{1'b0}}};
    localparam logic [RW-1:0] PRD_4M  = 23'h40_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CALC  = 3'd2,
        SEG   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q,     state_d;
    logic [31:0]     prd_addr_q,  prd_addr_d;
    logic [RW-1:0]   prd_rem_q,   prd_rem_d;
    logic            prd_end_q,   prd_end_d;
    logic [RW-1:0]   xfer_rem_q,  xfer_rem_d;
    logic            req_q,       req_d;
    logic            seg_valid_q, seg_valid_d;
    logic [31:0]     seg_addr_q,  seg_addr_d;
    logic [LW-1:0]   seg_len_q,   seg_len_d;
    logic            done_q,      done_d;
    logic            err_q,       err_d;
    logic [31:0]     prdbc_q,     prdbc_d;

    // Segment length = min(prd_rem, xfer_rem, distance to next boundary).
    // The boundary distance is at most SEG_MAX. Any counter with bits set
    // above the LW-bit range is therefore larger than the boundary distance.
    // Such a counter is clamped to SEG_MAX, so the whole compare fits in
    // LW bits.
    logic [LW-1:0] bnd;
    logic [LW-1:0] prd_rem_sat;
    logic [LW-1:0] xfer_rem_sat;
    logic [LW-1:0] lim;
    logic [LW-1:0] calc_len;

    always_comb begin
        bnd          = SEG_MAX - {1'b0, prd_addr_q[C_SEG_SHIFT-1:0]};
        prd_rem_sat  = (|prd_rem_q[RW-1:LW])  ? SEG_MAX : prd_rem_q[LW-1:0];
        xfer_rem_sat = (|xfer_rem_q[RW-1:LW]) ? SEG_MAX : xfer_rem_q[LW-1:0];
        lim          = (prd_rem_sat < xfer_rem_sat) ? prd_rem_sat : xfer_rem_sat;
        calc_len     = (bnd < lim) ? bnd : lim;
    end

    // Counter updates applied on a segment handshake.
    logic            seg_hs;
    logic [RW-1:0]   seg_len_rw;
    logic [31:0]     seg_len_32;
    logic [RW-1:0]   prd_rem_after;
    logic [RW-1:0]   xfer_rem_after;

    assign seg_hs         = seg_valid_q & bus.seg_ready;
    assign seg_len_rw     = {{(RW-LW){1'b0}}, seg_len_q};
    assign seg_len_32     = {{(32-LW){1'b0}}, seg_len_q};
    assign prd_rem_after  = prd_rem_q - seg_len_rw;
    assign xfer_rem_after = xfer_rem_q - seg_len_rw;

    always_comb begin
        state_d     = state_q;
        prd_addr_d  = prd_addr_q;
        prd_rem_d   = prd_rem_q;
        prd_end_d   = prd_end_q;
        xfer_rem_d  = xfer_rem_q;
        req_d       = req_q;
        seg_valid_d = seg_valid_q;
        seg_addr_d  = seg_addr_q;
        seg_len_d   = seg_len_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        prdbc_d     = prdbc_q;

        unique case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    xfer_rem_d = xfer_len;
                    if (xfer_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (prd_rem_q != '0) begin
                        state_d = CALC;
                    end else if (prd_end_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end
                end
            end

            FETCH: begin
                if (bus.ctba2al_ack) begin
                    req_d      = 1'b0;
                    prd_addr_d = bus.ctba2al_addr;
                    // A zero length field encodes a full 4 MiB entry.
                    prd_rem_d  = (bus.ctba2al_len == '0) ? PRD_4M
                                                         : {1'b0, bus.ctba2al_len};
                    prd_end_d  = bus.ctba2al_end;
                    state_d    = CALC;
                end
            end

            CALC: begin
                seg_addr_d  = prd_addr_q;
                seg_len_d   = calc_len;
                seg_valid_d = 1'b1;
                state_d     = SEG;
            end

            SEG: begin
                if (seg_hs) begin
                    seg_valid_d = 1'b0;
                    prd_addr_d  = prd_addr_q + seg_len_32;
                    prd_rem_d   = prd_rem_after;
                    xfer_rem_d  = xfer_rem_after;
                    prdbc_d     = prdbc_q + seg_len_32;
                    // A finished transfer wins over an exhausted PRD. The
                    // end flag only matters when more bytes are still owed.
                    if (xfer_rem_after == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (prd_rem_after == '0 && prd_end_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (prd_rem_after == '0) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Context clear overrides whatever the FSM decided this cycle.
        if (ctx_clr) begin
            state_d     = IDLE;
            req_d       = 1'b0;
            seg_valid_d = 1'b0;
            prd_rem_d   = '0;
            prd_end_d   = 1'b0;
            prdbc_d     = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            prd_addr_q  <= '0;
            prd_rem_q   <= '0;
            prd_end_q   <= 1'b0;
            xfer_rem_q  <= '0;
            req_q       <= 1'b0;
            seg_valid_q <= 1'b0;
            seg_addr_q  <= '0;
            seg_len_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            prdbc_q     <= '0;
        end else begin
            state_q     <= state_d;
            prd_addr_q  <= prd_addr_d;
            prd_rem_q   <= prd_rem_d;
            prd_end_q   <= prd_end_d;
            xfer_rem_q  <= xfer_rem_d;
            req_q       <= req_d;
            seg_valid_q <= seg_valid_d;
            seg_addr_q  <= seg_addr_d;
            seg_len_q   <= seg_len_d;
            done_q      <= done_d;
            err_q       <= err_d;
            prdbc_q     <= prdbc_d;
        end
    end

    assign bus.al2ctba_req = req_q;
    assign bus.seg_valid   = seg_valid_q;
    assign bus.seg_addr    = seg_addr_q;
    assign bus.seg_len     = seg_len_q;
    assign bus.dbg_state   = state_q;
    assign xfer_done       = done_q;
    assign xfer_err        = err_q;
    assign prdbc           = prdbc_q;
endmodule

// File: tb/tb_prd_seg.sv
// tb_prd_seg
//   Bench for prd_seg. A behavioural model walks a PRD table with plain
//   arithmetic and predicts, for each transfer:
//   - the segment list,
//   - the number of fetches,
//   - the error flag,
//   - prdbc.
//   A cycle loop plays the ctba fetcher and the segment consumer with random
//   delays and compares the DUT against that prediction.
module tb_prd_seg;
    localparam int S      = 12;
    localparam int LW     = S + 1;
    localparam int BUDGET = 400;
    localparam int unsigned SEGB = 32'd1 << S;

    typedef struct packed {
        logic [31:0] addr;
        logic [21:0] len;
        logic        last;
    } prd_t;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        xfer_start = 1'b0;
    logic [22:0] xfer_len   = '0;
    logic        ctx_clr    = 1'b0;
    logic        xfer_done;
    logic        xfer_err;
    logic [31:0] prdbc;

    prd_seg_if #(.C_SEG_SHIFT(S)) bus ();

    prd_seg #(.C_SEG_SHIFT(S)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .xfer_start (xfer_start),
        .xfer_len   (xfer_len),
        .ctx_clr    (ctx_clr),
        .xfer_done  (xfer_done),
        .xfer_err   (xfer_err),
        .prdbc      (prdbc),
        .bus        (bus)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    prd_t            prd_model_q[$];
    prd_t            prd_drv_q[$];
    logic [LW+31:0]  exp_q[$];

    // model context
    logic [31:0]  m_addr  = '0;
    int unsigned  m_rem   = 0;
    logic         m_end   = 1'b0;
    logic [31:0]  m_prdbc = '0;
    int           exp_fetch;
    logic         exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic add_prd(input logic [31:0] a, input logic [21:0] l, input logic last);
        prd_t p;
        p.addr = a;
        p.len  = l;
        p.last = last;
        prd_model_q.push_back(p);
        prd_drv_q.push_back(p);
    endtask

    task automatic new_prd();
        logic [31:0] a;
        logic [21:0] l;
        logic        last;
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[11:0] = 12'(32'hFFF - $urandom_range(0, 40));
        l    = ($urandom_range(0, 9) == 0) ? 22'd0 : 22'($urandom_range(1, 32'h2800));
        last = ($urandom_range(0, 5) == 0);
        add_prd(a, l, last);
    endtask

    task automatic model_clear();
        m_rem   = 0;
        m_end   = 1'b0;
        m_prdbc = '0;
    endtask

    // Walk the PRD table for one transfer and fill exp_q.
    task automatic model_xfer(input int unsigned len);
        int unsigned rem, bnd, s;
        prd_t p;
        rem = len;
        exp_q.delete();
        exp_fetch = 0;
        exp_err   = 1'b0;
        while (rem != 0 && !exp_err) begin
            if (m_rem == 0) begin
                if (m_end) begin
                    exp_err = 1'b1;
                end else begin
                    if (prd_model_q.size() == 0) new_prd();
                    p = prd_model_q.pop_front();
                    exp_fetch++;
                    m_addr = p.addr;
                    m_rem  = (p.len == 0) ? 32'h40_0000 : int'(p.len);
                    m_end  = p.last;
                end
            end
            if (!exp_err) begin
                bnd = SEGB - (m_addr % SEGB);
                s = rem;
                if (m_rem < s) s = m_rem;
                if (bnd < s)   s = bnd;
                exp_q.push_back({m_addr, LW'(s)});
                m_addr  = m_addr + s;
                m_rem   = m_rem - s;
                rem     = rem - s;
                m_prdbc = m_prdbc + s;
            end
        end
    endtask

    task automatic rand_ctba_fields();
        bus.ctba2al_addr = $urandom;
        bus.ctba2al_len  = 22'($urandom);
        bus.ctba2al_end  = 1'($urandom);
    endtask

    // One transfer, played against the model with random ack and ready timing.
    task automatic run_xfer(input string tag, input int unsigned len);
        int got_fetch, got_segs, n_exp, t_start, t_ack, t_hs, ack_wait;
        bit done_seen, prev_req, seg_open, no_work;
        logic [LW+31:0] e;
        prd_t p;
        model_xfer(len);
        n_exp     = exp_q.size();
        no_work   = (n_exp == 0) && (exp_fetch == 0);
        got_fetch = 0;
        got_segs  = 0;
        t_ack     = -1;
        t_hs      = -1;
        ack_wait  = -1;
        done_seen = 0;
        prev_req  = 0;
        seg_open  = 0;
        bus.seg_ready   = 1'b0;
        bus.ctba2al_ack = 1'b0;
        xfer_len   = 23'(len);
        xfer_start = 1'b1;
        t_start    = cyc;
        step();
        xfer_start = 1'b0;
        for (int i = 0; i < BUDGET && !done_seen; i++) begin
            if (xfer_done) begin
                done_seen = 1;
                chk({tag, "_err"}, xfer_err, exp_err);
                chk({tag, "_done_lat"}, cyc - (no_work ? t_start : t_hs), 1);
                chk({tag, "_nsegs"}, got_segs, n_exp);
                chk({tag, "_fetches"}, got_fetch, exp_fetch);
                chk({tag, "_prdbc"}, prdbc, m_prdbc);
            end else begin
                // fetcher
                bus.ctba2al_ack = 1'b0;
                rand_ctba_fields();
                if (bus.al2ctba_req && !prev_req) begin
                    got_fetch++;
                    ack_wait = $urandom_range(0, 3);
                end
                prev_req = bus.al2ctba_req;
                if (bus.al2ctba_req && ack_wait == 0) begin
                    if (prd_drv_q.size() != 0) begin
                        p = prd_drv_q.pop_front();
                        bus.ctba2al_ack  = 1'b1;
                        bus.ctba2al_addr = p.addr;
                        bus.ctba2al_len  = p.len;
                        bus.ctba2al_end  = p.last;
                        t_ack    = cyc;
                        ack_wait = -1;
                    end
                end else if (ack_wait > 0) begin
                    ack_wait--;
                end
                // consumer
                if (bus.seg_valid && !seg_open) begin
                    seg_open = 1;
                    if (t_ack >= 0)    chk({tag, "_ack2seg"}, cyc - t_ack, 2);
                    else if (t_hs < 0) chk({tag, "_start2seg"}, cyc - t_start, 2);
                    t_ack = -1;
                end
                bus.seg_ready = bus.seg_valid ? ($urandom_range(0, 3) != 0)
                                              : 1'($urandom_range(0, 1));
                if (bus.seg_valid && bus.seg_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk({tag, "_seg_addr"}, bus.seg_addr, e[LW+31:LW]);
                        chk({tag, "_seg_len"}, bus.seg_len, e[LW-1:0]);
                    end
                    got_segs++;
                    t_hs     = cyc;
                    seg_open = 0;
                end
                step();
            end
        end
        if (!done_seen) chk({tag, "_timeout"}, done_seen, 1);
        bus.seg_ready   = 1'b0;
        bus.ctba2al_ack = 1'b0;
        step();
        chk({tag, "_done_pulse"}, xfer_done, 0);
    endtask

    task automatic clear_ctx();
        ctx_clr = 1'b1;
        step();
        ctx_clr = 1'b0;
        model_clear();
        chk("clr_prdbc", prdbc, 0);
    endtask

    // n cycles in which nothing may come out of the DUT
    task automatic quiet(input string tag, input int n);
        bit bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            bus.seg_ready = ~bus.seg_ready;
            step();
            if (bus.seg_valid || xfer_done || bus.al2ctba_req) bad = 1;
        end
        bus.seg_ready = 1'b0;
        chk(tag, bad, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int unsigned len;
        bus.ctba2al_ack  = 1'b0;
        bus.ctba2al_addr = '0;
        bus.ctba2al_len  = '0;
        bus.ctba2al_end  = 1'b0;
        bus.seg_ready    = 1'b0;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_done",  xfer_done, 0);
        chk("rst_err",   xfer_err, 0);
        chk("rst_req",   bus.al2ctba_req, 0);
        chk("rst_valid", bus.seg_valid, 0);
        chk("rst_addr",  bus.seg_addr, 0);
        chk("rst_len",   bus.seg_len, 0);
        chk("rst_prdbc", prdbc, 0);
        sys_rst_n = 1'b1;
        step();

        // 1: two full 4 KiB segments out of one PRD
        add_prd(32'h1000_0000, 22'h2000, 1'b0);
        run_xfer("t1", 32'h2000);
        chk("t1_prdbc_abs", prdbc, 32'h2000);

        // 2: first segment stops at the 4 KiB boundary
        clear_ctx();
        add_prd(32'h0000_0F00, 22'h300, 1'b0);
        run_xfer("t2", 32'h300);

        // 3: leftover PRD context is reused without a fetch
        clear_ctx();
        add_prd(32'h2000_0000, 22'h3000, 1'b0);
        run_xfer("t3a", 32'h2000);
        run_xfer("t3b", 32'h1000);
        chk("t3_prdbc_abs", prdbc, 32'h3000);

        // 4: table ends before the transfer does; then an error straight from IDLE
        clear_ctx();
        add_prd(32'h0000_0000, 22'h800, 1'b0);
        add_prd(32'h0000_9000, 22'h800, 1'b1);
        run_xfer("t4", 32'h1800);
        chk("t4_prdbc_abs", prdbc, 32'h1000);
        run_xfer("t4b", 32'h100);

        // 5: zero length field means 4 MiB
        clear_ctx();
        add_prd(32'h4000_0000, 22'h0, 1'b0);
        run_xfer("t5a", 32'h1000);
        run_xfer("t5b", 32'h1000);
        run_xfer("t5z", 32'h0);

        // 6a: ctx_clr while a segment is stalled
        xfer_len   = 23'h3000;
        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        for (int i = 0; i < 10 && !bus.seg_valid; i++) step();
        chk("t6_valid_up", bus.seg_valid, 1);
        chk("t6_stall_addr", bus.seg_addr, 32'h4000_2000);
        ctx_clr = 1'b1;
        step();
        ctx_clr = 1'b0;
        model_clear();
        chk("t6_valid_drop", bus.seg_valid, 0);
        chk("t6_prdbc_clr", prdbc, 0);
        quiet("t6_quiet", 8);
        add_prd(32'h5000_0800, 22'h1800, 1'b0);
        run_xfer("t6b", 32'h1000);

        // 6c: ctx_clr during FETCH, late ack must be ignored
        clear_ctx();
        xfer_len   = 23'h100;
        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        for (int i = 0; i < 10 && !bus.al2ctba_req; i++) step();
        chk("t6c_req_up", bus.al2ctba_req, 1);
        ctx_clr = 1'b1;
        step();
        ctx_clr = 1'b0;
        model_clear();
        chk("t6c_req_drop", bus.al2ctba_req, 0);
        bus.ctba2al_ack  = 1'b1;
        bus.ctba2al_addr = 32'h7000_0000;
        bus.ctba2al_len  = 22'h100;
        bus.ctba2al_end  = 1'b0;
        step();
        bus.ctba2al_ack = 1'b0;
        quiet("t6c_quiet", 6);
        add_prd(32'h6000_0000, 22'h200, 1'b1);
        run_xfer("t6d", 32'h100);

        // 7: start and clear together in IDLE, the clear wins
        xfer_len   = 23'h80;
        xfer_start = 1'b1;
        ctx_clr    = 1'b1;
        step();
        xfer_start = 1'b0;
        ctx_clr    = 1'b0;
        model_clear();
        quiet("t7_quiet", 5);
        chk("t7_prdbc", prdbc, 0);
        run_xfer("t7", 32'h80);

        // random transfers against the model
        for (int n = 0; n < 40; n++) begin
            if ((m_end && m_rem == 0) || $urandom_range(0, 9) == 0) clear_ctx();
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 32'h3000);
            run_xfer("rnd", len);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prd_seg.md
Name: prd_seg

Overview:
- Sits between the DMA address layer and the ctba PRD fetcher.
- Pulls PRD entries from ctba over the al2ctba_req / ctba2al_ack handshake.
- Splits each data transfer into bus segments that never cross a 2^C_SEG_SHIFT-byte aligned boundary and never exceed the current PRD or transfer remainder.
- Keeps the partially consumed PRD context across transfers and accumulates the PRD byte count used for the UpdateBC write.

Parameters:
C_SEG_SHIFT, 12, log2 of maximum segment size and alignment boundary (4 KiB)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset, asynchronous, active-low
xfer_start  in  1  pulse: begin transfer of xfer_len bytes
xfer_len  in  23  transfer byte count
ctx_clr  in  1  pulse: discard PRD context, clear prdbc, abort
xfer_done  out  1  one-cycle pulse: transfer finished
xfer_err  out  1  one-cycle pulse, coincident with xfer_done: PRD table exhausted
al2ctba_req  out  1  request next PRD entry
ctba2al_ack  in  1  one-cycle pulse: PRD fields valid
ctba2al_addr  in  32  PRD data base address
ctba2al_len  in  22  PRD byte count (DBC+1); 0 encodes 4 MiB
ctba2al_end  in  1  this PRD is the table's last entry
seg_valid  out  1  segment descriptor valid
seg_ready  in  1  consumer accepts segment
seg_addr  out  32  segment start address
seg_len  out  C_SEG_SHIFT+1  segment bytes, 1..2^C_SEG_SHIFT
prdbc  out  32  cumulative bytes transferred since last ctx_clr

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Internal state is also 0: prd_addr, prd_rem (23 b), prd_end, xfer_rem.
- States: IDLE, FETCH, CALC, SEG, DONE.
- IDLE:
  - xfer_start latches xfer_rem = xfer_len.
  - xfer_len == 0 → DONE.
  - Otherwise, prd_rem != 0 → CALC.
  - Otherwise, prd_end == 1 → DONE with error.
  - Otherwise → FETCH.
  - xfer_start outside IDLE is ignored.
- FETCH:
  - al2ctba_req is registered and goes high on entry. It is held until ctba2al_ack and cleared on the edge that samples ack.
  - On ack: prd_addr = ctba2al_addr; prd_rem = (ctba2al_len == 0) ? 0x400000 : ctba2al_len; prd_end = ctba2al_end; then → CALC.
- CALC (1 cycle):
  - bnd = 2^S − prd_addr[S−1:0].
  - seg_len = min(prd_rem, xfer_rem, bnd); seg_addr = prd_addr.
  - Set seg_valid = 1; → SEG.
- SEG:
  - seg_valid, seg_addr and seg_len are held stable until seg_valid & seg_ready.
  - On handshake: seg_valid = 0; prd_addr += seg_len (32-bit wrap); prd_rem −= seg_len; xfer_rem −= seg_len; prdbc += seg_len (32-bit wrap).
  - Next state:
    - xfer_rem' == 0 → DONE. The leftover PRD context is retained.
    - Otherwise, prd_rem' == 0 and prd_end → DONE with error.
    - Otherwise, prd_rem' == 0 → FETCH.
    - Otherwise → CALC.
- DONE: xfer_done = 1 for one cycle; xfer_err = 1 on the same cycle if the error path was taken; → IDLE.
- Minimum latency:
  - Context present: start → seg_valid is 2 cycles.
  - Fetch needed: ack → seg_valid is 2 cycles.
  - Final handshake → xfer_done is 1 cycle.
- ctx_clr has priority over all events, in any state:
  - Next state IDLE; al2ctba_req = 0; seg_valid = 0.
  - prd_rem, prd_end and prdbc are cleared.
  - No xfer_done is generated.
  - A ctba2al_ack arriving after ctx_clr while in IDLE is ignored.
- Simultaneous xfer_start and ctx_clr in IDLE: the clear wins and the start is dropped.
- seg_len never equals 0 in SEG.

Test Plan:
1. PRD {0x1000_0000, len 0x2000, end 0}, xfer_len 0x2000 → segs (0x1000_0000, 0x1000), (0x1000_1000, 0x1000); xfer_done, xfer_err = 0, prdbc = 0x2000, one al2ctba_req.
2. PRD {0x0000_0F00, 0x300}, xfer_len 0x300 → segs (0x0F00, 0x100), (0x1000, 0x200).
3. PRD {0x2000_0000, 0x3000}, xfer 0x2000 then second xfer 0x1000 → second xfer issues no al2ctba_req; seg (0x2000_2000, 0x1000); prdbc = 0x3000.
4. PRDs {0x0, 0x800, end 0}, {0x9000, 0x800, end 1}, xfer 0x1800 → two fetches, segs 0x800 @0x0 and 0x800 @0x9000, then xfer_done with xfer_err = 1; prdbc = 0x1000.
5. PRD len field 0 at 0x4000_0000, xfer 0x1000 → one seg (0x4000_0000, 0x1000); next xfer 0x1000 needs no fetch and yields seg 0x4000_1000.
6. ctx_clr in SEG with seg_ready held low, then seg_ready toggling → seg_valid drops the next cycle, no xfer_done, prdbc = 0, next xfer_start triggers FETCH. Same ctx_clr pulse during FETCH with late ack → ack ignored.
